disp_scheduler: RTL and testbench

DISP_SCHEDULER -- requirements
Module: disp_scheduler

---
 rtl/disp_pkg.sv | 6 +
 rtl/disp_slot_pick.sv | 22 ++
 rtl/disp_scheduler.sv | 90 +++++++++
 tb/tb_disp_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the display scheduler
package disp_pkg;
  localparam int NUM_DISP = 4;
  typedef enum logic [1:0] {IDLE, LOAD, CLEAR} state_t;
  typedef logic [1:0] slot_t;
endpackage

// File: rtl/disp_slot_pick.sv
// disp_slot_pick: first enabled, not-yet-loaded slot searched upward from ptr with wrap
module disp_slot_pick
  import disp_pkg::*;
(
  input  logic [1:0]          ptr,
  input  logic [NUM_DISP-1:0] slot_en,
  input  logic [NUM_DISP-1:0] loaded,
  output logic [1:0]          slot,
  output logic                found
);
  // Walk from the farthest offset down so the nearest free slot after ptr wins
  always_comb begin
    slot = '0;
    found = 1'b0;
    for (int i = NUM_DISP - 1; i >= 0; i--) begin
      if (slot_en[ptr + 2'(i)] && !loaded[ptr + 2'(i)]) begin
        slot = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: loads accepted bytes into enabled display slots and clears the bank on request
module disp_scheduler #(
  parameter int HOLD_CYC = 1,
  parameter int NUM_DISP = disp_pkg::NUM_DISP
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [NUM_DISP-1:0] slot_en,
  input  logic                clear_req,
  output logic [7:0]          inp,
  output logic                priem,
  output logic                SET1,
  output logic                SET2,
  output logic                SET3,
  output logic                SET4,
  output logic                Reset_1,
  output logic                Reset_2,
  output logic                Reset_3,
  output logic                Reset_4,
  output logic                full,
  output logic [2:0]          fill_cnt
);
  import disp_pkg::*;
  state_t state;
  slot_t ptr, tgt, pick;
  logic [NUM_DISP-1:0] loaded;
  logic [7:0] byte_q;
  logic [3:0] cnt;
  logic pend, found, in_idle, in_load, in_clr, accept, take_clr, load_done;
  disp_slot_pick u_pick (
    .ptr(ptr),
    .slot_en(slot_en),
    .loaded(loaded),
    .slot(pick),
    .found(found)
  );
  assign in_idle = state == IDLE;
  assign in_load = state == LOAD;
  assign in_clr = state == CLEAR;
  assign full = !Reset && |slot_en && ((loaded & slot_en) == slot_en);
  // A clear arriving this very cycle already blocks acceptance so it wins over data
  assign data_ready = !Reset && in_idle && |slot_en && !full && !pend && !clear_req && found;
  assign accept = data_valid && data_ready;
  assign take_clr = in_idle && (pend || clear_req);
  assign load_done = in_load && cnt == 4'(HOLD_CYC - 1);
  assign priem = in_load;
  assign inp = in_load ? byte_q : 8'h00;
  assign {SET4, SET3, SET2, SET1} = in_load ? 4'b0001 << tgt : 4'b0000;
  assign {Reset_4, Reset_3, Reset_2, Reset_1} = {4{in_clr}};
  // Control FSM with slot bookkeeping; a clear seen during LOAD is remembered and run right after it
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ptr <= '0;
      tgt <= '0;
      loaded <= '0;
      fill_cnt <= '0;
      pend <= 1'b0;
      byte_q <= '0;
      cnt <= '0;
    end else if (in_clr) begin
      loaded <= '0;
      fill_cnt <= '0;
      ptr <= '0;
      pend <= clear_req;
      state <= IDLE;
    end else begin
      pend <= pend || clear_req;
      if (take_clr) begin
        state <= CLEAR;
      end else if (accept) begin
        byte_q <= data_in;
        tgt <= pick;
        cnt <= '0;
        state <= LOAD;
      end else if (in_load) begin
        cnt <= cnt + 4'd1;
        if (load_done) begin
          loaded[tgt] <= 1'b1;
          fill_cnt <= fill_cnt + 3'd1;
          ptr <= tgt + 2'd1;
          state <= (pend || clear_req) ? CLEAR : IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: vector table, corner sequences and randomized model check of disp_scheduler
module tb_disp_scheduler;
  localparam int HOLD = 1;
  logic clk = 0, Reset = 1, data_valid = 0, clear_req = 0;
  logic [7:0] data_in = 0;
  logic [3:0] slot_en = 0;
  wire ready, priem, full, ready3, priem3, full3;
  wire [7:0] inp, inp3;
  wire [3:0] setv, rstv, set3, rst3;
  wire [2:0] fill, fill3;
  wire [21:0] obs = {ready, priem, setv, inp, rstv, full, fill};
  wire [21:0] obs3 = {ready3, priem3, set3, inp3, rst3, full3, fill3};
  int n_pass = 0, n_tot = 0;
  disp_scheduler #(.HOLD_CYC(HOLD)) dut (
    .clk(clk), .Reset(Reset), .data_in(data_in), .data_valid(data_valid), .data_ready(ready),
    .slot_en(slot_en), .clear_req(clear_req), .inp(inp), .priem(priem),
    .SET1(setv[0]), .SET2(setv[1]), .SET3(setv[2]), .SET4(setv[3]),
    .Reset_1(rstv[0]), .Reset_2(rstv[1]), .Reset_3(rstv[2]), .Reset_4(rstv[3]),
    .full(full), .fill_cnt(fill)
  );
  disp_scheduler #(.HOLD_CYC(3)) dut3 (
    .clk(clk), .Reset(Reset), .data_in(data_in), .data_valid(data_valid), .data_ready(ready3),
    .slot_en(slot_en), .clear_req(clear_req), .inp(inp3), .priem(priem3),
    .SET1(set3[0]), .SET2(set3[1]), .SET3(set3[2]), .SET4(set3[3]),
    .Reset_1(rst3[0]), .Reset_2(rst3[1]), .Reset_3(rst3[2]), .Reset_4(rst3[3]),
    .full(full3), .fill_cnt(fill3)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic dv;
    logic [7:0] din;
    logic [3:0] en;
    logic clr;
    logic [21:0] exp;
  } vec_t;
  vec_t tbl[$];
  // reference model: slot occupancy, search pointer, pending clear and remaining load cycles
  int m_left, m_ptr, m_fill, m_tgt;
  bit m_clr, m_pend;
  bit [3:0] m_loaded;
  logic [7:0] m_byte;
  function automatic logic [21:0] ex(logic r, logic p, logic [3:0] s, logic [7:0] i, logic [3:0] c, logic f, logic [2:0] n);
    return {r, p, s, i, c, f, n};
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
    else n_pass++;
  endtask
  task automatic drv(logic dv, logic [7:0] din, logic [3:0] en, logic clr);
    @(negedge clk);
    data_valid = dv;
    data_in = din;
    slot_en = en;
    clear_req = clr;
    #1;
  endtask
  task automatic add(logic dv, logic [7:0] din, logic [3:0] en, logic clr, logic [21:0] e);
    vec_t v;
    v.dv = dv; v.din = din; v.en = en; v.clr = clr; v.exp = e;
    tbl.push_back(v);
  endtask
  task automatic m_reset();
    m_left = 0; m_ptr = 0; m_fill = 0; m_tgt = 0; m_clr = 0; m_pend = 0; m_loaded = 0; m_byte = 0;
  endtask
  function automatic logic [21:0] m_expect();
    bit fullv, rdy, ld;
    fullv = slot_en != 0 && (m_loaded & slot_en) == slot_en;
    rdy = m_left == 0 && !m_clr && slot_en != 0 && !fullv && !m_pend && !clear_req;
    ld = m_left > 0;
    return ex(rdy, ld, ld ? 4'(1 << m_tgt) : 4'h0, ld ? m_byte : 8'h00, m_clr ? 4'hF : 4'h0, fullv, 3'(m_fill));
  endfunction
  task automatic m_step();
    bit fullv, rdy;
    int t;
    fullv = slot_en != 0 && (m_loaded & slot_en) == slot_en;
    rdy = m_left == 0 && !m_clr && slot_en != 0 && !fullv && !m_pend && !clear_req;
    if (m_clr) begin
      m_loaded = 0; m_fill = 0; m_ptr = 0; m_pend = clear_req; m_clr = 0;
    end else if (m_left > 0) begin
      if (clear_req) m_pend = 1;
      m_left--;
      if (m_left == 0) begin
        m_loaded[m_tgt] = 1;
        m_fill++;
        m_ptr = (m_tgt + 1) % 4;
        m_clr = m_pend;
      end
    end else begin
      if (clear_req) m_pend = 1;
      if (m_pend) m_clr = 1;
      else if (data_valid && rdy) begin
        t = -1;
        for (int k = 0; k < 4; k++)
          if (t < 0 && slot_en[(m_ptr + k) % 4] && !m_loaded[(m_ptr + k) % 4]) t = (m_ptr + k) % 4;
        m_tgt = t;
        m_byte = data_in;
        m_left = HOLD;
      end
    end
  endtask
  task automatic do_reset();
    Reset = 1;
    drv(0, 0, 4'hF, 0);
    drv(0, 0, 4'hF, 0);
    Reset = 0;
  endtask
  initial begin
    add(1, 46, 4'hF, 0, ex(1, 0, 0, 0, 0, 0, 0));
    add(1, 47, 4'hF, 0, ex(0, 1, 4'h1, 46, 0, 0, 0));
    add(1, 47, 4'hF, 0, ex(1, 0, 0, 0, 0, 0, 1));
    add(1, 48, 4'hF, 0, ex(0, 1, 4'h2, 47, 0, 0, 1));
    add(1, 48, 4'hF, 0, ex(1, 0, 0, 0, 0, 0, 2));
    add(1, 49, 4'hF, 0, ex(0, 1, 4'h4, 48, 0, 0, 2));
    add(1, 49, 4'hF, 0, ex(1, 0, 0, 0, 0, 0, 3));
    add(0, 0, 4'hF, 0, ex(0, 1, 4'h8, 49, 0, 0, 3));
    add(0, 0, 4'hF, 0, ex(0, 0, 0, 0, 0, 1, 4));
    add(1, 77, 4'hF, 1, ex(0, 0, 0, 0, 0, 1, 4));
    add(1, 77, 4'hF, 0, ex(0, 0, 0, 0, 4'hF, 1, 4));
    add(1, 77, 4'hF, 0, ex(1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 4'hF, 0, ex(0, 1, 4'h1, 77, 0, 0, 0));
    add(0, 0, 4'hF, 0, ex(1, 0, 0, 0, 0, 0, 1));
    add(0, 0, 4'h5, 1, ex(0, 0, 0, 0, 0, 0, 1));
    add(0, 0, 4'h5, 0, ex(0, 0, 0, 0, 4'hF, 0, 1));
    add(1, 10, 4'h5, 0, ex(1, 0, 0, 0, 0, 0, 0));
    add(1, 20, 4'h5, 0, ex(0, 1, 4'h1, 10, 0, 0, 0));
    add(1, 20, 4'h5, 0, ex(1, 0, 0, 0, 0, 0, 1));
    add(0, 0, 4'h5, 0, ex(0, 1, 4'h4, 20, 0, 0, 1));
    add(0, 0, 4'h5, 0, ex(0, 0, 0, 0, 0, 1, 2));
    add(1, 55, 4'h0, 0, ex(0, 0, 0, 0, 0, 0, 2));
    add(1, 55, 4'h0, 1, ex(0, 0, 0, 0, 0, 0, 2));
    add(1, 55, 4'h0, 0, ex(0, 0, 0, 0, 4'hF, 0, 2));
    add(1, 55, 4'h0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    Reset = 1;
    drv(1, 8'h55, 4'hF, 0);
    chk("reset_outputs", 32'(obs), 0);
    chk("reset_outputs_h3", 32'(obs3), 0);
    drv(0, 0, 4'hF, 0);
    Reset = 0;
    foreach (tbl[i]) begin
      drv(tbl[i].dv, tbl[i].din, tbl[i].en, tbl[i].clr);
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end
    for (int k = 0; k < 10; k++) begin
      drv(1, 8'hAA, 4'h0, k == 4);
      chk($sformatf("noslot_rdy_priem%0d", k), {ready, priem}, 0);
      if (k == 5) chk("noslot_clear", 32'(rstv), 4'hF);
    end
    do_reset();
    drv(1, 8'h11, 4'hF, 0);
    drv(0, 0, 4'hF, 0);
    drv(1, 8'h22, 4'hF, 0);
    drv(0, 0, 4'hF, 0);
    chk("midload_before", {priem, setv, fill}, {1'b1, 4'h2, 3'd1});
    Reset = 1;
    #1;
    chk("midload_async", {priem, setv, fill, ready, full}, 0);
    Reset = 0;
    do_reset();
    drv(1, 8'd5, 4'hF, 0);
    chk("h3_accept", 32'(obs3), 32'(ex(1, 0, 0, 0, 0, 0, 0)));
    drv(0, 0, 4'hF, 0);
    chk("h3_load1", 32'(obs3), 32'(ex(0, 1, 4'h1, 5, 0, 0, 0)));
    drv(0, 0, 4'hF, 1);
    chk("h3_load2", 32'(obs3), 32'(ex(0, 1, 4'h1, 5, 0, 0, 0)));
    drv(0, 0, 4'hF, 0);
    chk("h3_load3", 32'(obs3), 32'(ex(0, 1, 4'h1, 5, 0, 0, 0)));
    drv(0, 0, 4'hF, 0);
    chk("h3_clear", 32'(obs3), 32'(ex(0, 0, 0, 0, 4'hF, 0, 1)));
    drv(1, 8'd6, 4'hF, 0);
    chk("h3_after", 32'(obs3), 32'(ex(1, 0, 0, 0, 0, 0, 0)));
    drv(0, 0, 4'hF, 0);
    chk("h3_ptr0", 32'(obs3), 32'(ex(0, 1, 4'h1, 6, 0, 0, 0)));
    do_reset();
    m_reset();
    slot_en = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      data_valid = $urandom_range(0, 3) != 0;
      data_in = 8'($urandom);
      clear_req = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 29) == 0) slot_en = 4'($urandom_range(0, 15));
      #1;
      chk($sformatf("rand%0d", c), 32'(obs), 32'(m_expect()));
      @(posedge clk);
      m_step();
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
